// File: rtl/jt12_pkg.sv
// Shared constants for the JT12 timer slice.
// Holds the default timer widths and the YM2612 clocking constants used to
// derive timer periods at system level.
package jt12_pkg;

  // Default counter geometry for the two timers
  localparam int unsigned CW_A_DEF   = 10;
  localparam int unsigned CW_B_DEF   = 8;
  localparam int unsigned PRES_B_DEF = 4;

  // YM2612 timing: master clock divided by 6 gives the FM clock, and one
  // output sample spans 24 operator slots (144 master clocks)
  localparam int unsigned YM_CLK_DIV     = 6;
  localparam int unsigned YM_SLOTS       = 24;
  localparam int unsigned YM_SAMPLE_CLKS = YM_CLK_DIV * YM_SLOTS;

endpackage

// File: rtl/jt12_timer_cnt.sv
// One reloadable timer: load-edge detector, optional tick prescaler,
// up-counter with reload on overflow, and a latched overflow flag.
// Ports: clk, rst (sync, active-high), cen (clock enable), zero (sample
// strobe), value (reload value), load (run/load level), clr_flag, en_flag,
// flag (latched overflow), ovf_c (combinational overflow strobe, valid in the
// cen cycle the counter wraps).
module jt12_timer_cnt import jt12_pkg::*; #(
  parameter int unsigned CW   = CW_B_DEF,
  parameter int unsigned PRES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          zero,
  input  logic [CW-1:0] value,
  input  logic          load,
  input  logic          clr_flag,
  input  logic          en_flag,
  output logic          flag,
  output logic          ovf_c
);

  logic [CW-1:0] cnt;
  logic          load_q;
  logic          load_rise_c;
  logic          pres_wrap_c;
  logic          adv_c;
  logic          full_c;

  assign load_rise_c = load & ~load_q;
  // Advance only while running and past the load cycle itself
  assign adv_c       = zero & load & load_q & pres_wrap_c;
  assign full_c      = &cnt;
  assign ovf_c       = cen & adv_c & full_c;

  // Tick prescaler; with no prescaler bits every tick advances the counter
  if (PRES == 0) begin : g_nopres
    assign pres_wrap_c = 1'b1;
  end else begin : g_pres
    logic [PRES-1:0] pres;

    always_ff @(posedge clk) begin
      if (rst) begin
        pres <= '0;
      end else if (cen) begin
        if (load_rise_c)
          pres <= '0;
        else if (zero)
          pres <= pres + PRES'(1);
      end
    end

    assign pres_wrap_c = &pres;
  end

  // Counter, load edge detector and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      load_q <= 1'b0;
      flag   <= 1'b0;
    end else if (cen) begin
      load_q <= load;
      if (load_rise_c)
        cnt <= value;
      else if (adv_c)
        cnt <= full_c ? value : cnt + CW'(1);
      // Set has priority over clear
      if (ovf_c && en_flag)
        flag <= 1'b1;
      else if (clr_flag)
        flag <= 1'b0;
    end
  end

endmodule

// File: rtl/jt12_timer_pair.sv
// YM2612 timer pair: timer A (no prescaler) and timer B (2^PRES_B prescaler),
// shared active-low interrupt and a one-cycle timer A overflow pulse.
// Ports: clk, rst (sync, active-high), cen, zero, value_A/value_B (reload
// values), load_A/load_B, clr_flag_A/B, en_flag_A/B, flag_A/flag_B (latched
// overflow flags), overflow_A (one-clk pulse), irq_n (low while a flag is set).
module jt12_timer_pair import jt12_pkg::*; #(
  parameter int unsigned CW_A   = CW_A_DEF,
  parameter int unsigned CW_B   = CW_B_DEF,
  parameter int unsigned PRES_B = PRES_B_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            zero,
  input  logic [CW_A-1:0] value_A,
  input  logic [CW_B-1:0] value_B,
  input  logic            load_A,
  input  logic            load_B,
  input  logic            clr_flag_A,
  input  logic            clr_flag_B,
  input  logic            en_flag_A,
  input  logic            en_flag_B,
  output logic            flag_A,
  output logic            flag_B,
  output logic            overflow_A,
  output logic            irq_n
);

  logic ovf_a_c;
  logic unused_ovf_b;

  jt12_timer_cnt #(.CW(CW_A), .PRES(0)) u_timer_a (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .zero     (zero),
    .value    (value_A),
    .load     (load_A),
    .clr_flag (clr_flag_A),
    .en_flag  (en_flag_A),
    .flag     (flag_A),
    .ovf_c    (ovf_a_c)
  );

  jt12_timer_cnt #(.CW(CW_B), .PRES(PRES_B)) u_timer_b (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .zero     (zero),
    .value    (value_B),
    .load     (load_B),
    .clr_flag (clr_flag_B),
    .en_flag  (en_flag_B),
    .flag     (flag_B),
    .ovf_c    (unused_ovf_b)
  );

  // Overflow pulse runs on every clk so it lasts exactly one cycle even when
  // cen is sparse
  always_ff @(posedge clk) begin
    if (rst)
      overflow_A <= 1'b0;
    else
      overflow_A <= ovf_a_c;
  end

  // Interrupt follows the flags one cen cycle later
  always_ff @(posedge clk) begin
    if (rst)
      irq_n <= 1'b1;
    else if (cen)
      irq_n <= ~(flag_A | flag_B);
  end

endmodule

// File: tb/tb_jt12_timer_pair.sv
// Self-checking bench for jt12_timer_pair: directed scenarios with fixed
// expectations plus randomized traffic, all outputs compared every cycle
// against an integer reference model.
module tb_jt12_timer_pair;

  localparam int unsigned CW_A   = 10;
  localparam int unsigned CW_B   = 8;
  localparam int unsigned PRES_B = 4;
  localparam int unsigned MOD_A  = 1 << CW_A;
  localparam int unsigned MOD_B  = 1 << CW_B;
  localparam int unsigned MOD_P  = 1 << PRES_B;

  logic            clk = 1'b0;
  logic            rst, cen, zero;
  logic [CW_A-1:0] value_A;
  logic [CW_B-1:0] value_B;
  logic            load_A, load_B, clr_flag_A, clr_flag_B, en_flag_A, en_flag_B;
  logic            flag_A, flag_B, overflow_A, irq_n;

  jt12_timer_pair #(.CW_A(CW_A), .CW_B(CW_B), .PRES_B(PRES_B)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .zero       (zero),
    .value_A    (value_A),
    .value_B    (value_B),
    .load_A     (load_A),
    .load_B     (load_B),
    .clr_flag_A (clr_flag_A),
    .clr_flag_B (clr_flag_B),
    .en_flag_A  (en_flag_A),
    .en_flag_B  (en_flag_B),
    .flag_A     (flag_A),
    .flag_B     (flag_B),
    .overflow_A (overflow_A),
    .irq_n      (irq_n)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: plain integers
  int unsigned m_ca, m_cb, m_pres;
  bit m_lqa, m_lqb, m_fa, m_fb, m_ovfa, m_irqn;

  task automatic model_step();
    bit ov_a, ov_b, rise_a, rise_b, pres_full;
    ov_a = 0;
    ov_b = 0;
    if (rst) begin
      m_ca = 0; m_cb = 0; m_pres = 0;
      m_lqa = 0; m_lqb = 0; m_fa = 0; m_fb = 0;
      m_ovfa = 0; m_irqn = 1;
    end else begin
      if (cen) begin
        rise_a    = load_A && !m_lqa;
        rise_b    = load_B && !m_lqb;
        pres_full = (m_pres == MOD_P - 1);
        if (rise_a) m_ca = int'(value_A);
        else if (load_A && zero) begin
          if (m_ca == MOD_A - 1) begin m_ca = int'(value_A); ov_a = 1; end
          else m_ca = (m_ca + 1) % MOD_A;
        end
        if (rise_b) m_cb = int'(value_B);
        else if (load_B && zero && pres_full) begin
          if (m_cb == MOD_B - 1) begin m_cb = int'(value_B); ov_b = 1; end
          else m_cb = (m_cb + 1) % MOD_B;
        end
        if (rise_b) m_pres = 0;
        else if (zero) m_pres = (m_pres + 1) % MOD_P;
        m_irqn = !(m_fa || m_fb);
        if (ov_a && en_flag_A) m_fa = 1; else if (clr_flag_A) m_fa = 0;
        if (ov_b && en_flag_B) m_fb = 1; else if (clr_flag_B) m_fb = 0;
        m_lqa = load_A;
        m_lqb = load_B;
      end
      m_ovfa = ov_a;
    end
  endtask

  // One clock: advance model at the edge, compare shortly after
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_eq("flag_A",     int'(flag_A),     int'(m_fa));
    check_eq("flag_B",     int'(flag_B),     int'(m_fb));
    check_eq("overflow_A", int'(overflow_A), int'(m_ovfa));
    check_eq("irq_n",      int'(irq_n),      int'(m_irqn));
  endtask

  task automatic reset_dut();
    rst = 1; cen = 0; zero = 0;
    load_A = 0; load_B = 0; clr_flag_A = 0; clr_flag_B = 0;
    en_flag_A = 0; en_flag_B = 0; value_A = '0; value_B = '0;
    cycle();
    cycle();
    check_eq("rst_flag_A", int'(flag_A), 0);
    check_eq("rst_flag_B", int'(flag_B), 0);
    check_eq("rst_ovf_A",  int'(overflow_A), 0);
    check_eq("rst_irq_n",  int'(irq_n), 1);
    rst = 0;
  endtask

  initial begin
    rst = 1; cen = 0; zero = 0;
    load_A = 0; load_B = 0; clr_flag_A = 0; clr_flag_B = 0;
    en_flag_A = 0; en_flag_B = 0; value_A = '0; value_B = '0;

    // Timer A, zero every 4th cycle: overflow every 16 cycles
    reset_dut();
    cen = 1; value_A = 10'd1020; load_A = 1;
    cycle();
    for (int i = 1; i <= 40; i++) begin
      zero = (i % 4 == 0);
      cycle();
      check_eq("a_period", int'(overflow_A), int'(i % 16 == 0));
    end

    // Timer B with prescaler: first flag after 32 ticks, irq one cycle later
    reset_dut();
    cen = 1; zero = 1; value_B = 8'd254; en_flag_B = 1; load_B = 1;
    cycle();
    for (int i = 1; i <= 34; i++) begin
      cycle();
      check_eq("b_flag", int'(flag_B), int'(i >= 32));
      check_eq("b_irq",  int'(irq_n),  int'(i < 33));
    end

    // Overflow with flag disabled: pulse only, no flag, no irq
    reset_dut();
    cen = 1; zero = 1; value_A = 10'd1023; en_flag_A = 0; load_A = 1;
    cycle();
    for (int i = 1; i <= 6; i++) begin
      cycle();
      check_eq("noen_ovf",  int'(overflow_A), 1);
      check_eq("noen_flag", int'(flag_A), 0);
      check_eq("noen_irq",  int'(irq_n), 1);
    end

    // Set beats a simultaneous clear; held clear then wins
    reset_dut();
    cen = 1; zero = 0; value_A = 10'd1023; en_flag_A = 1; load_A = 1;
    cycle();
    zero = 1; clr_flag_A = 1;
    cycle();
    check_eq("setwin_flag", int'(flag_A), 1);
    zero = 0;
    cycle();
    check_eq("clr_flag", int'(flag_A), 0);
    check_eq("clr_irq_mid", int'(irq_n), 0);
    cycle();
    check_eq("clr_irq", int'(irq_n), 1);
    clr_flag_A = 0;

    // cen toggling with zero stuck high halves the count rate
    reset_dut();
    cen = 1; zero = 1; value_A = 10'd1020; load_A = 1;
    cycle();
    for (int i = 1; i <= 24; i++) begin
      cen = (i % 2 == 0);
      cycle();
      check_eq("half_rate", int'(overflow_A), int'(i % 8 == 0));
    end

    // Reset mid-count with load held: restart from value_A
    reset_dut();
    cen = 1; zero = 0; value_A = 10'd1020; en_flag_A = 1; load_A = 1;
    cycle();
    zero = 1;
    cycle();
    cycle();
    rst = 1; cen = 0;
    cycle();
    check_eq("midrst_ovf",  int'(overflow_A), 0);
    check_eq("midrst_flag", int'(flag_A), 0);
    check_eq("midrst_irq",  int'(irq_n), 1);
    rst = 0; cen = 1;
    for (int i = 1; i <= 7; i++) begin
      cycle();
      check_eq("midrst_reload", int'(overflow_A), int'(i == 5));
    end

    // Randomized traffic against the model
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      cen  = ($urandom_range(0, 3) != 0);
      zero = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 39) == 0) load_A = ~load_A;
      if ($urandom_range(0, 79) == 0) load_B = ~load_B;
      if ($urandom_range(0, 15) == 0) value_A = CW_A'(MOD_A - 1 - $urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) value_B = CW_B'(MOD_B - 1 - $urandom_range(0, 2));
      clr_flag_A = ($urandom_range(0, 19) == 0);
      clr_flag_B = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) en_flag_A = ~en_flag_A;
      if ($urandom_range(0, 49) == 0) en_flag_B = ~en_flag_B;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/jt12_timer_pair.md
JT12_TIMER_PAIR -- requirements
Module: jt12_timer_pair

Interface
REQ-001 SHALL have parameter CW_A, default 10, width of timer A counter.
REQ-002 SHALL have parameter CW_B, default 8, width of timer B counter.
REQ-003 SHALL have parameter PRES_B, default 4, prescaler bits for timer B; timer B advances once every 2^PRES_B ticks.
REQ-004 SHALL have port clk  in  1  single clock; every register updates on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous reset, active-high.
REQ-006 SHALL have port cen  in  1  clock enable from the divider block (clk_en).
REQ-007 SHALL have port zero  in  1  sample-boundary strobe; a tick is a cycle with cen=1 and zero=1.
REQ-008 SHALL have port value_A  in  CW_A  timer A reload value.
REQ-009 SHALL have port value_B  in  CW_B  timer B reload value.
REQ-010 SHALL have ports load_A, load_B  in  1  run/load control level per timer.
REQ-011 SHALL have ports clr_flag_A, clr_flag_B  in  1  flag clear, level.
REQ-012 SHALL have ports en_flag_A, en_flag_B  in  1  allow overflow to set the flag.
REQ-013 SHALL have ports flag_A, flag_B  out  1  latched overflow flags.
REQ-014 SHALL have port overflow_A  out  1  one-cycle pulse on timer A overflow (used for CSM key-on).
REQ-015 SHALL have port irq_n  out  1  active-low interrupt, low while any flag is set.

Function
REQ-016 Counters, prescaler, load edge detectors, flags and irq_n SHALL update only in cycles with cen=1; all hold otherwise.
REQ-017 A rising edge of load_X (sampled on cen cycles) SHALL load counter X with value_X in that cycle; no tick counted in that cycle.
REQ-018 While load_X=1 and no load edge, each tick SHALL advance counter A by 1; counter B SHALL advance by 1 when the prescaler is at 2^PRES_B-1 on a tick.
REQ-019 Prescaler SHALL be free-running on ticks, wrapping 2^PRES_B-1 -> 0, and SHALL clear to 0 on a load_B rising edge.
REQ-020 While load_X=0 counter X SHALL hold its value; no overflow is generated.
REQ-021 Overflow of X SHALL occur on an advancing tick with counter at all-ones; counter SHALL then reload value_X (current input, not a stored copy), never pass through 0 unless value_X=0.
REQ-022 value_X = all-ones SHALL give an overflow on every advancing tick.
REQ-023 overflow_A SHALL be high exactly one clk cycle, the cycle after the overflowing tick is registered; independent of en_flag_A.
REQ-024 On overflow with en_flag_X=1, flag_X SHALL become 1 the following cycle; with en_flag_X=0 the flag is untouched.
REQ-025 clr_flag_X=1 on a cen cycle SHALL clear flag_X; simultaneous set and clear -> set wins.
REQ-026 Clearing en_flag_X SHALL NOT clear an already-set flag_X.
REQ-027 irq_n SHALL be registered: ~(flag_A | flag_B) one cen cycle after the flag changes.
REQ-028 Counter width arithmetic SHALL be modulo 2^CW_X; no saturation.

Reset
REQ-029 rst=1 SHALL, regardless of cen, set counters and prescaler to 0, load edge detectors to 0, flag_A=flag_B=0, overflow_A=0, irq_n=1.
REQ-030 Reset mid-count SHALL discard pending overflow; after release a held load_X=1 SHALL be seen as a rising edge on the first cen cycle.

Structure
REQ-031 Shared package jt12_pkg SHALL hold CW_A/CW_B/PRES_B defaults and YM2612 timing constants; no typedefs required.
REQ-032 One sub-module jt12_timer_cnt (width, prescaler bits parameters; PRES=0 for A) SHALL implement counter, load edge, reload, flag; instantiated twice; top holds irq_n and overflow_A.

Verification
REQ-033 cen=1 every cycle, zero every 4th, value_A=1020, load_A 0->1 -> overflow_A pulse after exactly 4 ticks (16 cycles), then every 4 ticks.
REQ-034 value_B=254, load_B rise, PRES_B=4 -> first overflow after 32 ticks; flag_B=1, irq_n=0 one cen cycle later with en_flag_B=1.
REQ-035 Overflow with en_flag_A=0 -> overflow_A pulses, flag_A stays 0, irq_n stays 1.
REQ-036 clr_flag_A asserted in the same cycle flag_A is being set -> flag_A=1; clr held next cycle -> flag_A=0, irq_n=1.
REQ-037 cen toggling 1/0 with zero stuck high -> count rate halves; cen=0 cycles change nothing.
REQ-038 rst pulsed with counter A at 1022, load_A held high -> all outputs at reset values; counter reloads value_A on first cen cycle after release.
